// File: rtl/audio_i2s_rx_pkg.sv
// Shared types and constants for the I2S receiver.
package audio_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LEFT     = 2'd1,
        RIGHT    = 2'd2
    } T_i2s_rx_state;

    localparam int unsigned C_wdog_limit = 1024;
    localparam int unsigned C_wdog_w     = 10;
    localparam int unsigned C_cnt_w      = 6;
    localparam logic [C_cnt_w-1:0] C_cnt_max = 6'd63;

endpackage

// File: rtl/audio_i2s_rx_if.sv
// Serial pins in, parallel samples out; master drives the pins, slave is the receiver.
interface audio_i2s_rx_if #(
    parameter int P_width = 16
);
    logic               I_sclk;
    logic               I_wclk;
    logic               I_data;
    logic [P_width-1:0] O_left;
    logic [P_width-1:0] O_right;
    logic               O_valid;
    logic               O_error;
    logic               O_locked;

    modport master (
        output I_sclk, I_wclk, I_data,
        input  O_left, O_right, O_valid, O_error, O_locked
    );

    modport slave (
        input  I_sclk, I_wclk, I_data,
        output O_left, O_right, O_valid, O_error, O_locked
    );
endinterface

// File: rtl/audio_i2s_rx_sync_edge.sv
// Synchroniser with rise detect on i_edge; i_d rides through the same depth so it stays aligned.
module sync_edge #(
    parameter int P_stages = 2,
    parameter int P_width  = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_edge,
    input  logic [P_width-1:0] i_d,
    output logic               o_rise,
    output logic [P_width-1:0] o_d
);
    logic [P_stages-1:0] r_edge_sync;
    logic                r_edge_dly;
    logic [P_width-1:0]  r_d_sync [P_stages];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_edge_sync <= '0;
            r_edge_dly  <= 1'b0;
            for (int i = 0; i < P_stages; i++) r_d_sync[i] <= '0;
        end else begin
            r_edge_sync <= {r_edge_sync[P_stages-2:0], i_edge};
            r_edge_dly  <= r_edge_sync[P_stages-1];
            r_d_sync[0] <= i_d;
            for (int i = 1; i < P_stages; i++) r_d_sync[i] <= r_d_sync[i-1];
        end
    end

    assign o_rise = r_edge_sync[P_stages-1] & ~r_edge_dly;
    assign o_d    = r_d_sync[P_stages-1];
endmodule

// File: rtl/audio_i2s_rx.sv
// Philips I2S receiver: oversampled bit clock, left/right deserialiser, lock FSM and watchdog.
// state    | meaning
// UNLOCKED | waiting for a wclk 1->0 boundary, data discarded
// LEFT     | assembling the left word
// RIGHT    | assembling the right word; its end publishes the pair
module audio_i2s_rx
    import audio_pkg::*;
#(
    parameter int P_width       = 16,
    parameter int P_sync_stages = 2
) (
    input  logic          I_clock,
    input  logic          I_reset,
    audio_i2s_rx_if.slave bus
);
    localparam logic [C_cnt_w-1:0]  L_width     = C_cnt_w'(P_width);
    localparam logic [C_cnt_w-1:0]  L_one       = C_cnt_w'(1);
    localparam logic [C_wdog_w-1:0] L_wdog_load = C_wdog_w'(C_wdog_limit - 1);

    T_i2s_rx_state        r_state;
    T_i2s_rx_state        w_state_nxt;
    logic                 w_rise;
    logic [1:0]           w_sync;
    logic                 w_wclk_s;
    logic                 w_data_s;
    logic                 w_bound;
    logic                 w_wdog_tc;
    logic                 w_shift;
    logic                 w_clr;
    logic                 w_latch_left;
    logic                 w_latch_right;
    logic [P_width-1:0]   w_shreg_sh;
    logic [C_cnt_w-1:0]   w_cnt_sh;
    logic [C_cnt_w-1:0]   w_shamt;
    logic [P_width-1:0]   w_word;

    logic                 r_wclk_prev;
    logic [P_width-1:0]   r_shreg;
    logic [C_cnt_w-1:0]   r_bit_cnt;
    logic [P_width-1:0]   r_hold;
    logic [P_width-1:0]   r_left;
    logic [P_width-1:0]   r_right;
    logic                 r_valid;
    logic                 r_error;
    logic                 r_locked;
    logic [C_wdog_w-1:0]  r_wdog;

    sync_edge #(
        .P_stages (P_sync_stages),
        .P_width  (2)
    ) u_sync (
        .i_clock (I_clock),
        .i_reset (I_reset),
        .i_edge  (bus.I_sclk),
        .i_d     ({bus.I_wclk, bus.I_data}),
        .o_rise  (w_rise),
        .o_d     (w_sync)
    );

    assign w_wclk_s  = w_sync[1];
    assign w_data_s  = w_sync[0];
    assign w_bound   = w_rise && (w_wclk_s != r_wclk_prev);
    assign w_wdog_tc = !w_rise && (r_wdog == '0);

    // Bits past P_width are dropped but still counted so over-length words flag an error.
    always_comb begin
        w_shreg_sh = r_shreg;
        w_cnt_sh   = r_bit_cnt;
        if (r_bit_cnt < L_width) begin
            w_shreg_sh = {r_shreg[P_width-2:0], w_data_s};
            w_cnt_sh   = r_bit_cnt + L_one;
        end else if (r_bit_cnt != C_cnt_max) begin
            w_cnt_sh = r_bit_cnt + L_one;
        end
    end

    assign w_shamt = L_width - w_cnt_sh;
    assign w_word  = (w_cnt_sh < L_width) ? (w_shreg_sh << w_shamt) : w_shreg_sh;

    always_comb begin
        w_state_nxt   = r_state;
        w_shift       = 1'b0;
        w_clr         = 1'b0;
        w_latch_left  = 1'b0;
        w_latch_right = 1'b0;
        if (w_rise) begin
            case (r_state)
                UNLOCKED: begin
                    if (w_bound && !w_wclk_s) begin
                        w_state_nxt = LEFT;
                        w_clr       = 1'b1;
                    end
                end
                LEFT: begin
                    w_shift = 1'b1;
                    if (w_bound) begin
                        w_latch_left = 1'b1;
                        w_state_nxt  = RIGHT;
                    end
                end
                RIGHT: begin
                    w_shift = 1'b1;
                    if (w_bound) begin
                        w_latch_right = 1'b1;
                        w_state_nxt   = LEFT;
                    end
                end
                default: w_state_nxt = UNLOCKED;
            endcase
        end else if (w_wdog_tc) begin
            w_state_nxt = UNLOCKED;
            w_clr       = 1'b1;
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            r_state <= UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            r_wclk_prev <= 1'b0;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_hold      <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_locked    <= 1'b0;
            r_wdog      <= '0;
        end else begin
            if (w_rise) r_wclk_prev <= w_wclk_s;

            if (w_clr) begin
                r_bit_cnt <= '0;
            end else if (w_latch_left || w_latch_right) begin
                r_shreg   <= w_shreg_sh;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_shreg   <= w_shreg_sh;
                r_bit_cnt <= w_cnt_sh;
            end

            if (w_latch_left) r_hold <= w_word;
            // Left and right are published together so a reader never sees a mixed pair.
            if (w_latch_right) begin
                r_right <= w_word;
                r_left  <= r_hold;
            end

            r_valid  <= w_latch_right;
            r_error  <= (w_latch_left || w_latch_right) && (w_cnt_sh != L_width);
            r_locked <= (w_state_nxt != UNLOCKED);

            if (w_rise) begin
                r_wdog <= L_wdog_load;
            end else if (r_wdog != '0) begin
                r_wdog <= r_wdog - C_wdog_w'(1);
            end
        end
    end

    assign bus.O_left   = r_left;
    assign bus.O_right  = r_right;
    assign bus.O_valid  = r_valid;
    assign bus.O_error  = r_error;
    assign bus.O_locked = r_locked;
endmodule

// File: tb/tb_audio_i2s_rx.sv
// Drives word-level I2S streams into audio_i2s_rx and compares against a frame-level model.
module tb_audio_i2s_rx;
    localparam int PW = 16;

    typedef struct {
        bit          chan;
        int          len;
        logic [31:0] val;
    } word_t;

    logic I_clock = 1'b0;
    logic I_reset = 1'b0;

    audio_i2s_rx_if #(.P_width(PW)) bus ();

    audio_i2s_rx #(
        .P_width       (PW),
        .P_sync_stages (2)
    ) dut (
        .I_clock (I_clock),
        .I_reset (I_reset),
        .bus     (bus)
    );

    always #5 I_clock = ~I_clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Monitor: records published pairs, error pulses and any output change without O_valid.
    logic [PW-1:0] obs_l[$];
    logic [PW-1:0] obs_r[$];
    int            n_err_obs = 0;
    int            hold_viol = 0;
    logic [PW-1:0] prev_l = '0;
    logic [PW-1:0] prev_r = '0;

    always @(negedge I_clock) begin
        if (I_reset) begin
            if (bus.O_valid) begin
                obs_l.push_back(bus.O_left);
                obs_r.push_back(bus.O_right);
            end
            if (bus.O_error) n_err_obs <= n_err_obs + 1;
            if (!bus.O_valid && (bus.O_left != prev_l || bus.O_right != prev_r))
                hold_viol <= hold_viol + 1;
        end
        prev_l <= bus.O_left;
        prev_r <= bus.O_right;
    end

    // Reference model working on whole words, not bits.
    word_t         g_words[$];
    logic [PW-1:0] exp_l[$];
    logic [PW-1:0] exp_r[$];
    int            exp_err;
    bit            exp_lock;
    logic [PW-1:0] last_l = '0;
    logic [PW-1:0] last_r = '0;

    function automatic logic [PW-1:0] align(input logic [31:0] v, input int n);
        if (n >= PW) return PW'(v >> (n - PW));
        else         return PW'(v << (PW - n));
    endfunction

    task automatic add_word(input bit chan, input int len, input logic [31:0] val);
        word_t w;
        logic [31:0] mask;
        mask  = (len >= 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
        w.chan = chan;
        w.len  = len;
        w.val  = val & mask;
        g_words.push_back(w);
    endtask

    task automatic model_seg(input bit next_chan);
        bit            lk;
        bit            ca;
        logic [PW-1:0] hold;
        lk   = 1'b0;
        hold = '0;
        exp_l.delete();
        exp_r.delete();
        exp_err = 0;
        for (int i = 0; i < g_words.size(); i++) begin
            ca = (i + 1 < g_words.size()) ? g_words[i+1].chan : next_chan;
            if (ca != g_words[i].chan) begin
                if (!lk) begin
                    if (g_words[i].chan && !ca) lk = 1'b1;
                end else begin
                    if (g_words[i].len != PW) exp_err++;
                    if (!g_words[i].chan) hold = align(g_words[i].val, g_words[i].len);
                    else begin
                        exp_l.push_back(hold);
                        exp_r.push_back(align(g_words[i].val, g_words[i].len));
                    end
                end
            end
        end
        exp_lock = lk;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge I_clock);
    endtask

    task automatic send_bit(input bit w, input bit d, input int h);
        bus.I_wclk = w;
        bus.I_data = d;
        idle(h);
        bus.I_sclk = 1'b1;
        idle(h);
        bus.I_sclk = 1'b0;
    endtask

    task automatic send_seg(input bit next_chan, input int h);
        bit ca;
        for (int i = 0; i < g_words.size(); i++) begin
            ca = (i + 1 < g_words.size()) ? g_words[i+1].chan : next_chan;
            for (int b = g_words[i].len - 1; b >= 0; b--)
                send_bit((b == 0) ? ca : g_words[i].chan, g_words[i].val[b], h);
        end
    endtask

    // Send the queued words, then compare everything published during the segment.
    task automatic run_seg(input string tag, input bit next_chan, input int h);
        int base_f;
        int base_e;
        int n;
        base_f = obs_l.size();
        base_e = n_err_obs;
        model_seg(next_chan);
        send_seg(next_chan, h);
        idle(12);
        n = obs_l.size() - base_f;
        chk({tag, "_frames"}, 32'(n), 32'(exp_l.size()));
        for (int k = 0; k < n && k < exp_l.size(); k++) begin
            chk({tag, "_left"},  32'(obs_l[base_f+k]), 32'(exp_l[k]));
            chk({tag, "_right"}, 32'(obs_r[base_f+k]), 32'(exp_r[k]));
        end
        chk({tag, "_errors"}, 32'(n_err_obs - base_e), 32'(exp_err));
        chk({tag, "_locked"}, 32'(bus.O_locked), 32'(exp_lock));
        if (exp_l.size() > 0) begin
            last_l = exp_l[exp_l.size()-1];
            last_r = exp_r[exp_r.size()-1];
        end
        g_words.delete();
    endtask

    task automatic pulse_reset();
        @(negedge I_clock);
        I_reset = 1'b0;
        idle(3);
        I_reset = 1'b1;
        idle(2);
    endtask

    task automatic rand_frames(input int nfr);
        int ll;
        int lr;
        add_word(1'b1, 16, $urandom);
        for (int f = 0; f < nfr; f++) begin
            ll = ($urandom_range(9, 0) < 7) ? 16 : int'($urandom_range(24, 8));
            lr = ($urandom_range(9, 0) < 7) ? 16 : int'($urandom_range(24, 8));
            add_word(1'b0, ll, $urandom);
            add_word(1'b1, lr, $urandom);
        end
        add_word(1'b0, 4, $urandom);
    endtask

    initial begin
        bus.I_sclk = 1'b0;
        bus.I_wclk = 1'b0;
        bus.I_data = 1'b0;
        idle(4);
        chk("rst_left",   32'(bus.O_left),   32'h0);
        chk("rst_right",  32'(bus.O_right),  32'h0);
        chk("rst_valid",  32'(bus.O_valid),  32'h0);
        chk("rst_error",  32'(bus.O_error),  32'h0);
        chk("rst_locked", 32'(bus.O_locked), 32'h0);
        I_reset = 1'b1;
        idle(2);

        add_word(1'b1, 16, 32'h0000_1357);
        add_word(1'b0, 16, 32'h0000_8001);
        add_word(1'b1, 16, 32'h0000_7FFE);
        add_word(1'b0, 4,  32'h5);
        run_seg("loop", 1'b0, 4);

        pulse_reset();
        add_word(1'b1, 7,  32'h55);
        add_word(1'b0, 16, 32'h0000_1234);
        add_word(1'b1, 16, 32'h0000_ABCD);
        add_word(1'b0, 4,  32'h3);
        run_seg("midframe", 1'b0, 3);

        pulse_reset();
        add_word(1'b1, 24, 32'h0012_3456);
        add_word(1'b0, 24, 32'h00A5_A5A5);
        add_word(1'b1, 24, $urandom);
        add_word(1'b0, 4,  32'h9);
        run_seg("long", 1'b0, 3);

        pulse_reset();
        add_word(1'b1, 12, 32'h0000_0ABC);
        add_word(1'b0, 12, $urandom);
        add_word(1'b1, 12, 32'h0000_0FFF);
        add_word(1'b0, 4,  32'h1);
        run_seg("short", 1'b0, 5);

        for (int r = 0; r < 3; r++) begin
            pulse_reset();
            rand_frames(6);
            run_seg("rand", 1'b0, int'($urandom_range(6, 3)));
        end

        // Bit clock stops: lock must drop while the last pair holds.
        idle(2000);
        chk("wdog_locked", 32'(bus.O_locked), 32'h0);
        chk("wdog_left",   32'(bus.O_left),   32'(last_l));
        chk("wdog_right",  32'(bus.O_right),  32'(last_r));
        rand_frames(2);
        run_seg("relock", 1'b0, 4);

        pulse_reset();
        add_word(1'b1, 16, $urandom);
        add_word(1'b0, 16, 32'h0000_C3C3);
        add_word(1'b1, 16, 32'h0000_5A5A);
        add_word(1'b0, 8,  32'h0000_00E7);
        run_seg("prerst", 1'b0, 4);
        @(negedge I_clock);
        I_reset = 1'b0;
        #1;
        chk("midrst_left",   32'(bus.O_left),   32'h0);
        chk("midrst_right",  32'(bus.O_right),  32'h0);
        chk("midrst_locked", 32'(bus.O_locked), 32'h0);
        idle(3);
        I_reset = 1'b1;
        add_word(1'b0, 8,  32'h0000_0042);
        add_word(1'b1, 16, $urandom);
        add_word(1'b0, 16, 32'h0000_2468);
        add_word(1'b1, 16, 32'h0000_9BDF);
        add_word(1'b0, 4,  32'h2);
        run_seg("postrst", 1'b0, 4);

        chk("hold_viol", 32'(hold_viol), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
